// File: rtl/video_pkg.sv
// Shared types and default raster timing for the display scanout path.
package video_pkg;

    localparam int unsigned DEF_DISPLAY_WIDTH  = 100;
    localparam int unsigned DEF_DISPLAY_HEIGHT = 100;
    localparam int unsigned DEF_H_FRONT        = 4;
    localparam int unsigned DEF_H_SYNC         = 8;
    localparam int unsigned DEF_H_BACK         = 4;
    localparam int unsigned DEF_V_FRONT        = 2;
    localparam int unsigned DEF_V_SYNC         = 2;
    localparam int unsigned DEF_V_BACK         = 2;
    localparam int unsigned RGB565_BITS        = 16;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        IDLE,
        RUN
    } scan_state_t;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v position counters with active, sync and frame-wrap decode.
module video_timing_counter
    import video_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int unsigned H_FRONT        = DEF_H_FRONT,
    parameter int unsigned H_SYNC         = DEF_H_SYNC,
    parameter int unsigned H_BACK         = DEF_H_BACK,
    parameter int unsigned V_FRONT        = DEF_V_FRONT,
    parameter int unsigned V_SYNC         = DEF_V_SYNC,
    parameter int unsigned V_BACK         = DEF_V_BACK,
    localparam int unsigned H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW      = cnt_bits(H_TOTAL),
    localparam int unsigned VW      = cnt_bits(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          frame_wrap
);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(DISPLAY_WIDTH);
    localparam logic [HW-1:0] H_SYNC_START = HW'(DISPLAY_WIDTH + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(DISPLAY_HEIGHT);
    localparam logic [VW-1:0] V_SYNC_START = VW'(DISPLAY_HEIGHT + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Counters sit at the origin whenever scanout is not running.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_comb begin
        active     = en && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs         = en && (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
        vs         = en && (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
        frame_wrap = en && h_last && v_last;
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Walks the RGB565 framebuffer in raster order and emits pixels aligned to
// hsync/vsync/de with a fixed two-cycle latency from the counter position.
module framebuffer_scanout
    import video_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH         = DEF_DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT        = DEF_DISPLAY_HEIGHT,
    parameter int unsigned H_FRONT               = DEF_H_FRONT,
    parameter int unsigned H_SYNC                = DEF_H_SYNC,
    parameter int unsigned H_BACK                = DEF_H_BACK,
    parameter int unsigned V_FRONT               = DEF_V_FRONT,
    parameter int unsigned V_SYNC                = DEF_V_SYNC,
    parameter int unsigned V_BACK                = DEF_V_BACK,
    parameter int unsigned FRAMEBUFFER_DATA_BITS = RGB565_BITS,
    parameter int unsigned FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int unsigned FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_rd_addr,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
    output logic [4:0]                       pixel_r,
    output logic [5:0]                       pixel_g,
    output logic [4:0]                       pixel_b,
    output logic                             de,
    output logic                             hsync_n,
    output logic                             vsync_n,
    output logic                             frame_done
);

    localparam int unsigned H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = cnt_bits(H_TOTAL);
    localparam int unsigned VW      = cnt_bits(V_TOTAL);
    localparam int unsigned AW      = FRAMEBUFFER_ADDR_BITS;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(FRAMEBUFFER_SIZE - 1);
    localparam logic [HW-1:0] H_PIX_LAST = HW'(DISPLAY_WIDTH - 1);
    localparam logic [VW-1:0] V_PIX_LAST = VW'(DISPLAY_HEIGHT - 1);

    scan_state_t   state;
    logic          run;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          hs;
    logic          vs;
    logic          frame_wrap;
    logic          last_pix;

    logic          s1_valid;
    logic          s1_active;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_last;
    logic          s1_de;
    rgb565_t       px;

    assign run = (state == RUN);

    video_timing_counter #(
        .DISPLAY_WIDTH (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
        .H_FRONT       (H_FRONT),
        .H_SYNC        (H_SYNC),
        .H_BACK        (H_BACK),
        .V_FRONT       (V_FRONT),
        .V_SYNC        (V_SYNC),
        .V_BACK        (V_BACK)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .en        (run),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active),
        .hs        (hs),
        .vs        (vs),
        .frame_wrap(frame_wrap)
    );

    assign last_pix = active && (h_cnt == H_PIX_LAST) && (v_cnt == V_PIX_LAST);

    // enable only matters in IDLE or at the frame wrap, so a frame always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (enable)                 state <= RUN;
                RUN:  if (frame_wrap && !enable)  state <= IDLE;
            endcase
        end
    end

    // Incremental read address; saturates after the last pixel until the wrap.
    always_ff @(posedge clk) begin
        if (rst || !run || frame_wrap) begin
            fb_rd_addr <= '0;
        end else if (active && (fb_rd_addr != ADDR_LAST)) begin
            fb_rd_addr <= fb_rd_addr + AW'(1);
        end
    end

    // Stage 1: timing decode delayed to meet the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            s1_valid  <= run;
            s1_active <= active;
            s1_hs     <= hs;
            s1_vs     <= vs;
            s1_last   <= last_pix;
        end
    end

    assign s1_de = s1_valid && s1_active;
    assign px    = rgb565_t'(fb_rd_data[RGB565_BITS-1:0]);

    // Stage 2: registered video outputs, colour blanked outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            de         <= 1'b0;
            hsync_n    <= 1'b1;
            vsync_n    <= 1'b1;
            frame_done <= 1'b0;
            pixel_r    <= '0;
            pixel_g    <= '0;
            pixel_b    <= '0;
        end else begin
            de         <= s1_de;
            hsync_n    <= !(s1_valid && s1_hs);
            vsync_n    <= !(s1_valid && s1_vs);
            frame_done <= s1_valid && s1_last;
            pixel_r    <= s1_de ? px.r : '0;
            pixel_g    <= s1_de ? px.g : '0;
            pixel_b    <= s1_de ? px.b : '0;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomised scoreboard bench for framebuffer_scanout on a 4x3 raster.
module tb_framebuffer_scanout;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int HF   = 1;
    localparam int HS   = 2;
    localparam int HB   = 1;
    localparam int VF   = 1;
    localparam int VS   = 1;
    localparam int VB   = 1;
    localparam int HT   = W + HF + HS + HB;
    localparam int VT   = H + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT;
    localparam int SIZE = W * H;
    localparam int AW   = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [AW-1:0] fb_rd_addr;
    logic [15:0]   fb_rd_data;
    logic [4:0]    pixel_r;
    logic [5:0]    pixel_g;
    logic [4:0]    pixel_b;
    logic          de;
    logic          hsync_n;
    logic          vsync_n;
    logic          frame_done;

    framebuffer_scanout #(
        .DISPLAY_WIDTH        (W),
        .DISPLAY_HEIGHT       (H),
        .H_FRONT              (HF),
        .H_SYNC               (HS),
        .H_BACK               (HB),
        .V_FRONT              (VF),
        .V_SYNC               (VS),
        .V_BACK               (VB),
        .FRAMEBUFFER_DATA_BITS(16),
        .FRAMEBUFFER_SIZE     (SIZE),
        .FRAMEBUFFER_ADDR_BITS(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data),
        .pixel_r   (pixel_r),
        .pixel_g   (pixel_g),
        .pixel_b   (pixel_b),
        .de        (de),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .frame_done(frame_done)
    );

    typedef struct {
        int unsigned   cyc;
        logic          de;
        logic          hs_n;
        logic          vs_n;
        logic          fd;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t        tq[$];
    logic [15:0] pq[$];
    logic [15:0] mem [16];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          exp_fd = 0;
    int          act_fd = 0;

    // Reference model: frame position t in 0..FRAME_CLKS-1, or -1 when idle.
    bit m_run = 0;
    int m_t = 0;
    int pos0 = -1, pos1 = -1, pos2 = -1;
    bit rst0 = 1, rst1 = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) fb_rd_data <= mem[fb_rd_addr];

    // Read address expected at frame position t: active pixels already passed, saturated.
    function automatic logic [AW-1:0] exp_addr(input int t);
        int h, v, c;
        h = t % HT;
        v = t / HT;
        c = (v < H) ? v * W + ((h < W) ? h : W) : SIZE;
        if (c > SIZE - 1) c = SIZE - 1;
        return AW'(c);
    endfunction

    task automatic step(input bit r, input bit e);
        exp_t x;
        int   h, v;
        @(negedge clk);
        rst    = r;
        enable = e;
        if (r) begin
            m_run = 0;
            m_t   = 0;
        end else if (!m_run) begin
            if (e) begin
                m_run = 1;
                m_t   = 0;
            end
        end else if (m_t == FRAME_CLKS - 1) begin
            m_t = 0;
            if (!e) m_run = 0;
        end else begin
            m_t++;
        end
        pos2 = pos1;
        pos1 = pos0;
        pos0 = m_run ? m_t : -1;
        rst1 = rst0;
        rst0 = r;

        x.cyc  = cyc + 1;
        x.de   = 1'b0;
        x.hs_n = 1'b1;
        x.vs_n = 1'b1;
        x.fd   = 1'b0;
        x.addr = (pos0 < 0) ? '0 : exp_addr(pos0);
        if (!rst0 && !rst1 && pos2 >= 0) begin
            h = pos2 % HT;
            v = pos2 / HT;
            x.de   = (h < W) && (v < H);
            x.hs_n = !((h >= W + HF) && (h < W + HF + HS));
            x.vs_n = !((v >= H + VF) && (v < H + VF + VS));
            x.fd   = (h == W - 1) && (v == H - 1);
            if (x.de) pq.push_back(mem[v * W + h]);
            if (x.fd) exp_fd++;
        end
        tq.push_back(x);
    endtask

    function automatic bit drained();
        return !m_run && pos0 < 0 && pos1 < 0 && pos2 < 0;
    endfunction

    task automatic drain();
        int k = 0;
        while (!drained() && k < 200) begin
            step(0, 0);
            k++;
        end
        repeat (3) step(0, 0);
    endtask

    task automatic run_until(input int t);
        int k = 0;
        while (!(m_run && m_t == t) && k < 200) begin
            step(0, 1);
            k++;
        end
    endtask

    // Monitor: cycle-timed check of sync/de/addr, pixel queue popped on every de.
    initial begin
        exp_t        e;
        logic [15:0] w;
        forever begin
            @(negedge clk);
            while (tq.size() > 0 && tq[0].cyc < cyc) begin
                e = tq.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_expect cyc=%0d expected_cyc=%0d", cyc, e.cyc);
            end
            if (tq.size() > 0 && tq[0].cyc == cyc) begin
                e = tq.pop_front();
                checks++;
                if (de !== e.de || hsync_n !== e.hs_n || vsync_n !== e.vs_n ||
                    frame_done !== e.fd || fb_rd_addr !== e.addr ||
                    (!e.de && {pixel_r, pixel_g, pixel_b} !== 16'h0000)) begin
                    errors++;
                    $display("FAIL timing cyc=%0d got de=%b hs_n=%b vs_n=%b fd=%b addr=%0d rgb=%h want de=%b hs_n=%b vs_n=%b fd=%b addr=%0d rgb_blank=%b",
                             cyc, de, hsync_n, vsync_n, frame_done, fb_rd_addr,
                             {pixel_r, pixel_g, pixel_b}, e.de, e.hs_n, e.vs_n, e.fd, e.addr, !e.de);
                end
            end
            if (frame_done === 1'b1) act_fd++;
            if (de === 1'b1) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d got unexpected de with rgb=%h, want no pixel",
                             cyc, {pixel_r, pixel_g, pixel_b});
                end else begin
                    w = pq.pop_front();
                    if (pixel_r !== w[15:11] || pixel_g !== w[10:5] || pixel_b !== w[4:0]) begin
                        errors++;
                        $display("FAIL pixel cyc=%0d got r=%h g=%h b=%h want r=%h g=%h b=%h",
                                 cyc, pixel_r, pixel_g, pixel_b, w[15:11], w[10:5], w[4:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit en_r;
        rst    = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);

        // Reset held with enable asserted: everything stays inactive.
        repeat (3) step(1, 1);

        // Two frames of word == address.
        repeat (2 * FRAME_CLKS) step(0, 1);
        drain();

        // Colour split on pixel 0, random elsewhere; enable dropped on line 1.
        for (int i = 0; i < SIZE; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hF81F;
        run_until(HT);
        drain();

        // Restart, then reset in the middle of pixel 6.
        run_until(HT + 2);
        step(1, 1);
        repeat (FRAME_CLKS + 10) step(0, 1);
        drain();

        // Random enable and reset activity; memory changes only while fully idle.
        en_r = 1;
        for (int i = 0; i < 900; i++) begin
            if (drained() && $urandom_range(0, 3) == 0)
                for (int j = 0; j < SIZE; j++) mem[j] = 16'($urandom);
            if ($urandom_range(0, 39) == 0) en_r = !en_r;
            step($urandom_range(0, 149) == 0, en_r);
        end
        drain();

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pq.size() != 0 || tq.size() != 0) begin
            errors++;
            $display("FAIL leftover got pixels=%0d records=%0d want 0 0", pq.size(), tq.size());
        end
        checks++;
        if (act_fd != exp_fd) begin
            errors++;
            $display("FAIL frame_done_count got %0d want %0d", act_fd, exp_fd);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
